// File: rtl/wishbone_simple_master_32.sv
// One-at-a-time load/store to Wishbone B3 classic master: big-endian lane steering, read extraction,
// misalignment check, bus timeout. Response 2 edges after accept with a 1-cycle-ack slave; ready only in IDLE.
module wishbone_simple_master_32 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_misaligned_o,
  output logic        rsp_timeout_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [15:0] CNT_LAST  = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
  localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic [15:0] cnt;
  logic        we_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;

  logic        req_mis;
  logic [3:0]  sel_nxt;
  logic [31:0] dat_nxt;
  logic [31:0] rd_lane;

  assign req_ready_o = (state == S_IDLE);

  always_comb begin
    req_mis = (req_size_i == 2'd3) ||
              (req_size_i == 2'd1 && req_addr_i[0]) ||
              (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0);
    sel_nxt = 4'b1111;
    dat_nxt = req_wdata_i;
    case (req_size_i)
      2'd0: begin
        sel_nxt = 4'b1000 >> req_addr_i[1:0];
        dat_nxt = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        sel_nxt = req_addr_i[1] ? 4'b0011 : 4'b1100;
        dat_nxt = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Byte offset 0 lives in bits 31:24.
  always_comb begin
    rd_lane = wb_dat_i;
    case (size_q)
      2'd0: begin
        case (off_q)
          2'd0:    rd_lane = {24'd0, wb_dat_i[31:24]};
          2'd1:    rd_lane = {24'd0, wb_dat_i[23:16]};
          2'd2:    rd_lane = {24'd0, wb_dat_i[15:8]};
          default: rd_lane = {24'd0, wb_dat_i[7:0]};
        endcase
      end
      2'd1:    rd_lane = off_q[1] ? {16'd0, wb_dat_i[15:0]} : {16'd0, wb_dat_i[31:16]};
      default: rd_lane = wb_dat_i;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state            <= S_IDLE;
      cnt              <= 16'd0;
      we_q             <= 1'b0;
      off_q            <= 2'd0;
      size_q           <= 2'd0;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= 32'd0;
      rsp_err_o        <= 1'b0;
      rsp_misaligned_o <= 1'b0;
      rsp_timeout_o    <= 1'b0;
      wb_adr_o         <= 32'd0;
      wb_dat_o         <= 32'd0;
      wb_sel_o         <= 4'd0;
      wb_we_o          <= 1'b0;
      wb_cyc_o         <= 1'b0;
      wb_stb_o         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            off_q    <= req_addr_i[1:0];
            size_q   <= req_size_i;
            wb_adr_o <= req_addr_i;
            if (req_mis) begin
              state            <= S_RESP;
              rsp_valid_o      <= 1'b1;
              rsp_err_o        <= 1'b1;
              rsp_misaligned_o <= 1'b1;
            end else begin
              state    <= S_BUS;
              cnt      <= 16'd0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= req_we_i;
              wb_sel_o <= sel_nxt;
              wb_dat_o <= dat_nxt;
            end
          end
        end
        S_BUS: begin
          if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
          if (wb_err_i || wb_ack_i || (TMO_EN && cnt == CNT_LAST)) begin
            state       <= S_RESP;
            rsp_valid_o <= 1'b1;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= 4'd0;
            // Slave termination on the terminal cycle takes priority over timeout; err over ack.
            if (wb_err_i) begin
              rsp_err_o <= 1'b1;
            end else if (wb_ack_i) begin
              rsp_rdata_o <= we_q ? 32'd0 : rd_lane;
            end else begin
              rsp_err_o     <= 1'b1;
              rsp_timeout_o <= 1'b1;
            end
          end
        end
        S_RESP: begin
          state            <= S_IDLE;
          rsp_valid_o      <= 1'b0;
          rsp_rdata_o      <= 32'd0;
          rsp_err_o        <= 1'b0;
          rsp_misaligned_o <= 1'b0;
          rsp_timeout_o    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
